// File: rtl/pio_pkg.sv
// Shared definitions for the parallel I/O peripheral: register word addresses,
// edge-capture modes and the edge-selection helper used by the top level.
package pio_pkg;

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd2;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

    function automatic logic [31:0] edge_select(input edge_mode_e  mode,
                                                input logic [31:0] cur,
                                                input logic [31:0] prev);
        logic [31:0] rise;
        logic [31:0] fall;
        logic [31:0] res;
        rise = cur & ~prev;
        fall = ~cur & prev;
        case (mode)
            EDGE_FALL: res = fall;
            EDGE_ANY:  res = rise | fall;
            default:   res = rise;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// One input bit: 2-flop synchroniser, candidate register and saturating stability
// counter. The debounced output follows the candidate once it has held DB_CYCLES cycles.
module pio_debounce
    import pio_pkg::*;
#(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic deb_q, deb_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
        end
    end

    generate
        if (DB_CYCLES == 0) begin : g_bypass
            always_comb deb_d = sync2_q;
        end else begin : g_count
            localparam int              CW      = $clog2(DB_CYCLES + 1);
            localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES);

            logic          cand_q, cand_d;
            logic [CW-1:0] cnt_q, cnt_d;

            // Any disagreement restarts the stability count; the count saturates.
            always_comb begin
                cand_d = cand_q;
                cnt_d  = cnt_q;
                deb_d  = deb_q;
                if (sync2_q != cand_q) begin
                    cand_d = sync2_q;
                    cnt_d  = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_q == CNT_MAX) begin
                    deb_d = cand_q;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cand_q <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    cand_q <= cand_d;
                    cnt_q  <= cnt_d;
                end
            end
        end
    endgenerate

    assign dout = deb_q;

endmodule

// File: rtl/avalon_pio_irq.sv
// Generic Avalon-MM parallel I/O slave: output register with atomic set/clear,
// debounced and edge-captured inputs, and a maskable level interrupt.
module avalon_pio_irq
    import pio_pkg::*;
#(
    parameter int          IN_W      = 8,
    parameter int          OUT_W     = 8,
    parameter int          DB_CYCLES = 50000,
    parameter int          EDGE_MODE = 0,
    parameter logic [31:0] OUT_RESET = 32'd0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [IN_W-1:0]  in_export,
    output logic [OUT_W-1:0] out_export
);

    localparam edge_mode_e MODE = (EDGE_MODE == 1) ? EDGE_FALL :
                                  (EDGE_MODE == 2) ? EDGE_ANY  : EDGE_RISE;

    logic [IN_W-1:0]  deb;
    logic [IN_W-1:0]  deb_dly_q, deb_dly_d;
    logic [IN_W-1:0]  mask_q, mask_d;
    logic [IN_W-1:0]  cap_q, cap_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      deb_w, dly_w, edge_w, rd_word;
    logic [IN_W-1:0]  edges;
    logic             unused_bits;

    for (genvar i = 0; i < IN_W; i++) begin : g_in
        pio_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (clk_clk),
            .rst_n (reset_reset_n),
            .din   (in_export[i]),
            .dout  (deb[i])
        );
    end

    always_comb begin
        deb_w             = '0;
        dly_w             = '0;
        deb_w[IN_W-1:0]   = deb;
        dly_w[IN_W-1:0]   = deb_dly_q;
        edge_w            = edge_select(MODE, deb_w, dly_w);
        edges             = edge_w[IN_W-1:0];
        deb_dly_d         = deb;
    end

    always_comb begin
        rd_word = '0;
        case (avs_address)
            ADDR_DATA_IN:  rd_word[IN_W-1:0]  = deb;
            ADDR_DATA_OUT: rd_word[OUT_W-1:0] = out_q;
            ADDR_IRQ_MASK: rd_word[IN_W-1:0]  = mask_q;
            ADDR_EDGE_CAP: rd_word[IN_W-1:0]  = cap_q;
            default:       rd_word            = '0;
        endcase
    end

    // Avalon transfers: avs_read/avs_write are accepted on the edge that samples them
    // (no waitrequest); readdata is registered from pre-write state one cycle later.
    always_comb begin
        out_d   = out_q;
        mask_d  = mask_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        if (avs_write) begin
            case (avs_address)
                ADDR_DATA_OUT: out_d  = avs_writedata[OUT_W-1:0];
                ADDR_OUT_SET:  out_d  = out_q | avs_writedata[OUT_W-1:0];
                ADDR_OUT_CLR:  out_d  = out_q & ~avs_writedata[OUT_W-1:0];
                ADDR_IRQ_MASK: mask_d = avs_writedata[IN_W-1:0];
                ADDR_EDGE_CAP: cap_d  = cap_q & ~avs_writedata[IN_W-1:0];
                default:       ;
            endcase
        end
        // A new edge overrides a clear landing in the same cycle.
        cap_d = cap_d | edges;
        if (avs_read) begin
            rdata_d = rd_word;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            out_q     <= OUT_RESET[OUT_W-1:0];
            mask_q    <= '0;
            cap_q     <= '0;
            deb_dly_q <= '0;
            rdata_q   <= '0;
        end else begin
            out_q     <= out_d;
            mask_q    <= mask_d;
            cap_q     <= cap_d;
            deb_dly_q <= deb_dly_d;
            rdata_q   <= rdata_d;
        end
    end

    assign unused_bits  = ^{avs_writedata, edge_w};
    assign irq          = |(cap_q & mask_q);
    assign avs_readdata = rdata_q;
    assign out_export   = out_q;

endmodule

// File: tb/tb_avalon_pio_irq.sv
// Bench for avalon_pio_irq: two instances (debounced rising-edge and bypassed any-edge)
// share one bus; a table, directed corner sequences and random traffic are checked.
module tb_avalon_pio_irq;

    logic        clk;
    logic        rst_n;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;
    logic [7:0]  in0, out0;
    logic [3:0]  in1;
    logic [5:0]  out1;

    int   n_chk;
    int   n_err;
    logic mdl_en;

    avalon_pio_irq #(.IN_W(8), .OUT_W(8), .DB_CYCLES(4), .EDGE_MODE(0), .OUT_RESET(32'hA5)) u_dut0 (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd0), .irq(irq0),
        .in_export(in0), .out_export(out0)
    );

    avalon_pio_irq #(.IN_W(4), .OUT_W(6), .DB_CYCLES(0), .EDGE_MODE(2), .OUT_RESET(32'h15)) u_dut1 (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(rd1), .irq(irq1),
        .in_export(in1), .out_export(out1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // DATA_IN takes pin value v once the pin has been sampled as v on D+1 consecutive
    // cycles, seen 3 cycles later; with D = 0 it is the pin sampled 2 cycles earlier.
    logic [31:0] m_out [2];
    logic [31:0] m_mask[2];
    logic [31:0] m_cap [2];
    logic [31:0] m_rd  [2];
    logic [31:0] m_deb [2];
    logic [31:0] m_prev[2];
    logic [31:0] hist  [2][16];

    function automatic logic [31:0] model_read(input int i, input logic [2:0] a);
        case (a)
            3'd0:    return m_deb[i];
            3'd1:    return m_out[i];
            3'd4:    return m_mask[i];
            3'd5:    return m_cap[i];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input int i, input int d, input int mode, input logic [31:0] im,
                              input logic [31:0] om, input logic [31:0] orst, input logic [31:0] pin);
        logic [31:0] edges;
        logic [31:0] nd;
        if (!rst_n) begin
            m_out[i] = orst; m_mask[i] = 0; m_cap[i] = 0; m_rd[i] = 0;
            m_deb[i] = 0; m_prev[i] = 0;
            for (int k = 0; k < 16; k++) hist[i][k] = 0;
            return;
        end
        if (avs_read) m_rd[i] = model_read(i, avs_address);
        case (mode)
            0:       edges = m_deb[i] & ~m_prev[i];
            1:       edges = ~m_deb[i] & m_prev[i];
            default: edges = m_deb[i] ^ m_prev[i];
        endcase
        edges = edges & im;
        for (int k = 15; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = pin & im;
        nd = m_deb[i];
        if (d == 0) begin
            nd = hist[i][2];
        end else begin
            for (int b = 0; b < 32; b++) begin
                logic all1, all0;
                all1 = 1'b1; all0 = 1'b1;
                for (int k = 3; k <= 3 + d; k++) begin
                    all1 = all1 & hist[i][k][b];
                    all0 = all0 & ~hist[i][k][b];
                end
                if (all1) nd[b] = 1'b1;
                else if (all0) nd[b] = 1'b0;
            end
        end
        m_prev[i] = m_deb[i];
        m_deb[i]  = nd;
        if (avs_write) begin
            case (avs_address)
                3'd1: m_out[i]  = avs_writedata & om;
                3'd2: m_out[i]  = (m_out[i] | avs_writedata) & om;
                3'd3: m_out[i]  = m_out[i] & ~avs_writedata;
                3'd4: m_mask[i] = avs_writedata & im;
                3'd5: m_cap[i]  = m_cap[i] & ~avs_writedata;
                default: ;
            endcase
        end
        m_cap[i] = (m_cap[i] | edges) & im;
    endtask

    always @(posedge clk) begin
        model_step(0, 4, 0, 32'hFF, 32'hFF, 32'hA5, {24'b0, in0});
        model_step(1, 0, 2, 32'hF,  32'h3F, 32'h15, {28'b0, in1});
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mdl_en) begin
            check("mdl_out0", {24'b0, out0}, m_out[0]);
            check("mdl_out1", {26'b0, out1}, m_out[1]);
            check("mdl_irq0", {31'b0, irq0}, {31'b0, |(m_cap[0] & m_mask[0])});
            check("mdl_irq1", {31'b0, irq1}, {31'b0, |(m_cap[1] & m_mask[1])});
            check("mdl_rd0", rd0, m_rd[0]);
            check("mdl_rd1", rd1, m_rd[1]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus(input logic wr, input logic rd, input logic [2:0] a, input logic [31:0] d);
        avs_write = wr; avs_read = rd; avs_address = a; avs_writedata = d;
        @(posedge clk);
        @(negedge clk);
        avs_write = 1'b0; avs_read = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs[18];

    // ---------------- stimulus ----------------
    initial begin
        n_chk = 0; n_err = 0; mdl_en = 1'b1;
        rst_n = 1'b0; in0 = '0; in1 = '0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;

        vecs = '{
            '{1'b1, 1'b0, 3'd1, 32'h3C,  1'b0, 32'h00, 8'h3C},
            '{1'b1, 1'b0, 3'd2, 32'h03,  1'b0, 32'h00, 8'h3F},
            '{1'b1, 1'b0, 3'd3, 32'h30,  1'b0, 32'h00, 8'h0F},
            '{1'b0, 1'b1, 3'd1, 32'h00,  1'b1, 32'h0F, 8'h0F},
            '{1'b1, 1'b0, 3'd0, 32'hFF,  1'b0, 32'h00, 8'h0F},
            '{1'b0, 1'b1, 3'd0, 32'h00,  1'b1, 32'h00, 8'h0F},
            '{1'b1, 1'b1, 3'd1, 32'h55,  1'b1, 32'h0F, 8'h55},
            '{1'b0, 1'b1, 3'd1, 32'h00,  1'b1, 32'h55, 8'h55},
            '{1'b1, 1'b0, 3'd4, 32'h1FF, 1'b0, 32'h00, 8'h55},
            '{1'b0, 1'b1, 3'd4, 32'h00,  1'b1, 32'hFF, 8'h55},
            '{1'b1, 1'b0, 3'd7, 32'hFF,  1'b0, 32'h00, 8'h55},
            '{1'b0, 1'b1, 3'd7, 32'h00,  1'b1, 32'h00, 8'h55},
            '{1'b0, 1'b1, 3'd2, 32'h00,  1'b1, 32'h00, 8'h55},
            '{1'b1, 1'b0, 3'd2, 32'hF0,  1'b0, 32'h00, 8'hF5},
            '{1'b1, 1'b0, 3'd3, 32'hFF,  1'b0, 32'h00, 8'h00},
            '{1'b1, 1'b1, 3'd4, 32'h00,  1'b1, 32'hFF, 8'h00},
            '{1'b0, 1'b1, 3'd4, 32'h00,  1'b1, 32'h00, 8'h00},
            '{1'b0, 1'b1, 3'd5, 32'h00,  1'b1, 32'h00, 8'h00}
        };

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out0", {24'b0, out0}, 32'hA5);
        check("rst_irq0", {31'b0, irq0}, 32'h0);
        check("rst_rd0", rd0, 32'h0);
        rst_n = 1'b1;
        bus(1'b0, 1'b1, 3'd0, 32'h0);
        check("rst_data_in", rd0, 32'h0);

        // Register table.
        for (int v = 0; v < 18; v++) begin
            bus(vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].wdata);
            check($sformatf("vec%0d_out", v), {24'b0, out0}, {24'b0, vecs[v].exp_out});
            if (vecs[v].chk_rd) check($sformatf("vec%0d_rd", v), rd0, vecs[v].exp_rd);
        end

        // Debounce latency: pin sampled high at edge 0, DATA_IN high from edge 7.
        in0[0] = 1'b1; avs_read = 1'b1; avs_address = 3'd0;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("db_rise_k%0d", k), rd0, (k >= 8) ? 32'h1 : 32'h0);
        end
        avs_read = 1'b0;
        in0[0] = 1'b0;
        cycles(12);

        // A 3-cycle high pulse never reaches DATA_IN.
        in0[0] = 1'b1; avs_read = 1'b1; avs_address = 3'd0;
        for (int k = 0; k < 18; k++) begin
            if (k == 3) in0[0] = 1'b0;
            @(posedge clk); @(negedge clk);
            check($sformatf("db_pulse_k%0d", k), rd0, 32'h0);
        end
        avs_read = 1'b0;

        // Edge capture and irq on a clean rise.
        bus(1'b1, 1'b0, 3'd5, 32'hFF);
        bus(1'b1, 1'b0, 3'd4, 32'h01);
        in0[0] = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("irq_rise_k%0d", k), {31'b0, irq0}, (k >= 8) ? 32'h1 : 32'h0);
        end
        bus(1'b0, 1'b1, 3'd5, 32'h0);
        check("cap_after_rise", rd0, 32'h01);
        bus(1'b1, 1'b0, 3'd5, 32'h01);
        check("irq_after_w1c", {31'b0, irq0}, 32'h0);
        in0[0] = 1'b0;
        cycles(12);
        bus(1'b0, 1'b1, 3'd5, 32'h0);
        check("cap_after_fall", rd0, 32'h0);
        check("irq_after_fall", {31'b0, irq0}, 32'h0);

        // W1C of bit 1 on the very edge that captures a new rise on bit 1.
        in1 = 4'b0000;
        in0[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); @(negedge clk);
        end
        bus(1'b1, 1'b0, 3'd5, 32'h02);
        bus(1'b0, 1'b1, 3'd5, 32'h0);
        check("collision_cap", rd0, 32'h02);

        // Masking on the any-edge instance.
        bus(1'b1, 1'b0, 3'd4, 32'h02);
        in1 = 4'b0011;
        cycles(6);
        check("mask_irq1_set", {31'b0, irq1}, 32'h1);
        bus(1'b1, 1'b0, 3'd5, 32'h02);
        check("mask_irq1_clr", {31'b0, irq1}, 32'h0);
        bus(1'b0, 1'b1, 3'd5, 32'h0);
        check("mask_cap1", rd1, 32'h01);

        // Reset two cycles after a rise; the rise is re-qualified from scratch.
        in0 = 8'h00;
        cycles(12);
        bus(1'b1, 1'b0, 3'd5, 32'hFF);
        in0[0] = 1'b1;
        cycles(2);
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        bus(1'b1, 1'b0, 3'd4, 32'h01);
        avs_read = 1'b1; avs_address = 3'd0;
        for (int k = 5; k <= 14; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("rst_mid_din_k%0d", k), rd0, (k >= 12) ? 32'h1 : 32'h0);
            check($sformatf("rst_mid_irq_k%0d", k), {31'b0, irq0}, (k >= 12) ? 32'h1 : 32'h0);
        end
        avs_read = 1'b0;
        bus(1'b0, 1'b1, 3'd5, 32'h0);
        check("rst_mid_cap", rd0, 32'h01);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int b0;
            int b1;
            int op;
            b0 = $urandom_range(0, 7);
            b1 = $urandom_range(0, 3);
            if ($urandom_range(0, 5) == 0) in0[b0] = ~in0[b0];
            if ($urandom_range(0, 9) == 0) in1[b1] = ~in1[b1];
            rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
            op = $urandom_range(0, 3);
            avs_read      = op[0];
            avs_write     = op[1];
            avs_address   = 3'($urandom_range(0, 7));
            avs_writedata = $urandom;
            @(posedge clk); @(negedge clk);
        end
        avs_read = 1'b0; avs_write = 1'b0; rst_n = 1'b1;
        cycles(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/avalon_pio_irq.md
# avalon_pio_irq

Parametrised Avalon-MM slave parallel I/O peripheral that replaces the fixed 8-bit LED, 8-bit switch and 2-bit key PIOs in the lab SoC with one generic block. Each instance has a configurable-width output register with atomic set/clear, and a configurable-width input port. The input path is synchronised, debounced per bit and edge-captured, and drives a maskable interrupt. It sits on the system interconnect beside the SDRAM controller, and its exports go to the board LEDs, switches and keys.

## Interface
Parameters:
- IN_W, 8: input port width (1–32).
- OUT_W, 8: output port width (1–32).
- DB_CYCLES, 50000: number of stable cycles required before a debounced input bit changes. 0 bypasses the debounce stage.
- EDGE_MODE, 0: edge type captured. 0 = rising, 1 = falling, 2 = either.
- OUT_RESET, 0: reset value of the output register.

Ports:
- clk_clk, in, 1: sole clock. All logic is on its rising edge.
- reset_reset_n, in, 1: reset, synchronous, active-low.
- avs_address, in, 3: word address.
- avs_read, in, 1: read strobe.
- avs_write, in, 1: write strobe.
- avs_writedata, in, 32: write data.
- avs_readdata, out, 32: read data, fixed latency 1.
- irq, out, 1: level interrupt.
- in_export, in, IN_W: raw asynchronous inputs (switches, keys).
- out_export, out, OUT_W: output register (LEDs).

## Operation
- Register map by word address. Reads of unused bits return 0. Writes to read-only addresses are ignored.
  - 0 DATA_IN (RO): debounced input value.
  - 1 DATA_OUT (RW): output register.
  - 2 OUT_SET (WO): every written 1 sets the matching output bit.
  - 3 OUT_CLR (WO): every written 1 clears the matching output bit.
  - 4 IRQ_MASK (RW): per-input interrupt enable.
  - 5 EDGE_CAP (R/W1C): captured edges. Writing 1 clears that bit.
  - 6 and 7: read 0, writes ignored.
- Input path, per bit:
  - A 2-flop synchroniser feeds the debounce stage.
  - The debounce counter resets whenever the synchronised bit differs from the sampled candidate.
  - When the counter reaches DB_CYCLES, the debounced bit takes the candidate value.
- Edge detection compares the debounced value against its 1-cycle-delayed copy, according to EDGE_MODE.
  - A detected edge sets the EDGE_CAP bit.
  - If a set and a W1C clear of the same bit land in the same cycle, the set wins.
- irq = OR over bits of (EDGE_CAP & IRQ_MASK), decoded combinationally from registers only.
- Simultaneous read and write in one cycle:
  - The write takes effect.
  - readdata returns the pre-write register value.
- No waitrequest. The slave accepts every transfer in a single cycle.

## Timing
- Reset values:
  - out_export = OUT_RESET.
  - avs_readdata = 0.
  - irq = 0.
  - IRQ_MASK = 0.
  - EDGE_CAP = 0.
  - Synchroniser, candidate and debounced registers = 0.
  - Counters = 0.
- Reset asserted mid-debounce or mid-read discards all state. No edge is generated on reset release, even if inputs are high.
- Write latency: out_export changes on the edge that samples avs_write.
- Read latency: avs_readdata is valid exactly 1 cycle after avs_read. At other times it holds its last value.
- Input latency for a clean pin change at cycle 0, with DB_CYCLES = D > 0:
  - DATA_IN updates at cycle D+3.
  - The EDGE_CAP bit sets at D+4.
  - irq rises at D+4 if the bit is masked in.
- With DB_CYCLES = 0: DATA_IN updates at cycle 2 and EDGE_CAP sets at cycle 3.
- Bounce: a glitch shorter than D cycles never changes DATA_IN. The counter restarts on every toggle.
- Counter width is clog2(DB_CYCLES+1). It saturates and never wraps.

## Structure
- Shared package pio_pkg holds:
  - Address constants ADDR_DATA_IN through ADDR_EDGE_CAP.
  - Enum edge_mode_e (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- Sub-module pio_debounce: one per input bit, instantiated via generate. It contains the synchroniser, candidate register and counter, and is parametrised by DB_CYCLES.
- The top level holds the register file, edge logic, read mux and irq.

## Test plan
- Reset and out: with OUT_RESET = 8'hA5, hold reset 3 cycles.
  - out_export = A5, irq = 0 and DATA_IN = 0.
  - Write DATA_OUT = 3C, then OUT_SET = 03, then OUT_CLR = 30: out_export reads back 0F.
- Debounce: set DB_CYCLES = 4 and drive in_export[0] high at cycle 0.
  - DATA_IN reads 1 starting from cycle 7.
  - A 3-cycle high pulse never changes DATA_IN.
- Edge and irq: EDGE_MODE = 0, IRQ_MASK = 01, then a clean rise on bit 0.
  - EDGE_CAP = 01 and irq = 1.
  - Writing EDGE_CAP = 01 drops irq the next cycle.
  - A falling edge does not set the bit.
- Set versus clear collision: a W1C write to EDGE_CAP bit 1 in the same cycle as a new edge on bit 1 leaves EDGE_CAP[1] = 1.
- Masking: edges on bits 0 and 1 with IRQ_MASK = 02 and EDGE_MODE = 2.
  - irq = 1.
  - Clearing bit 1 only drops irq even though EDGE_CAP[0] = 1.
- Mid-operation reset: assert reset 2 cycles after a pin rise while in_export stays high.
  - After release, EDGE_CAP stays 0.
  - DATA_IN reaches 1 after D+3 cycles.
  - Then EDGE_CAP[0] sets, because the first debounced rise after reset is a genuine edge.
